// File: rtl/btb_update.sv
// BTB update engine: queues resolved branches, reads the indexed 2-way set,
// and writes back a modified set with counter, target, tag and LRU updates.
module btb_update (
    input  logic         clk,
    input  logic         rst,
    input  logic         upd_valid,
    input  logic [31:0]  upd_pc,
    input  logic         upd_taken,
    input  logic [31:0]  upd_target,
    output logic         upd_ready,
    output logic [2:0]   update_index,
    input  logic [127:0] update_set,
    output logic [2:0]   write_index,
    output logic [127:0] write_set,
    output logic         write_en,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StLookup, StWrite} state_e;

    state_e state_q;

    // Update queue: pc[1:0] never affects index or tag, so it is not stored.
    logic [29:0] fifo_pc     [4];
    logic [31:0] fifo_target [4];
    logic [3:0]  fifo_taken;
    logic [1:0]  wr_ptr_q;
    logic [1:0]  rd_ptr_q;
    logic [2:0]  count_q;

    logic        push;
    logic        pop;
    logic        unused_pc;

    // Working register holding the update currently being processed.
    logic [29:0] wk_pc_q;
    logic        wk_taken_q;
    logic [31:0] wk_target_q;

    // Lookup datapath.
    logic [26:0] tag;
    logic [63:0] way0;
    logic [63:0] way1;
    logic        hit0;
    logic        hit1;
    logic        hit;
    logic        victim;
    logic        sel_way;
    logic [63:0] old_way;
    logic [1:0]  ctr_new;
    logic [63:0] new_way;
    logic [63:0] way0_new;
    logic [63:0] way1_new;
    logic        need_write;

    assign unused_pc = ^upd_pc[1:0];

    assign upd_ready = (count_q != 3'd4);
    assign push      = upd_valid && upd_ready;
    assign pop       = (state_q == StIdle) && (count_q != 3'd0);
    assign busy      = (count_q != 3'd0) || (state_q != StIdle);

    assign update_index = wk_pc_q[2:0];
    assign write_index  = wk_pc_q[2:0];

    // Queue storage; contents are don't-care while the pointers mark it empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]     <= upd_pc[31:2];
            fifo_target[wr_ptr_q] <= upd_target;
            fifo_taken[wr_ptr_q]  <= upd_taken;
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            if (push && !pop) begin
                count_q <= count_q + 3'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 3'd1;
            end
        end
    end

    // Hit detection, victim choice and construction of the replacement set.
    always_comb begin
        tag    = wk_pc_q[29:3];
        way0   = update_set[63:0];
        way1   = update_set[127:64];
        hit0   = way0[63] && (way0[62:36] == tag);
        hit1   = way1[63] && (way1[62:36] == tag);
        hit    = hit0 || hit1;
        // First invalid way, otherwise the LRU pointer in set[0].
        victim = !way0[63] ? 1'b0 : (!way1[63] ? 1'b1 : update_set[0]);
        // Way0 wins when both ways hit.
        sel_way = hit ? !hit0 : victim;
        old_way = sel_way ? way1 : way0;

        ctr_new = old_way[3:2];
        if (wk_taken_q) begin
            if (old_way[3:2] != 2'b11) begin
                ctr_new = old_way[3:2] + 2'b01;
            end
        end else begin
            if (old_way[3:2] != 2'b00) begin
                ctr_new = old_way[3:2] - 2'b01;
            end
        end

        if (hit) begin
            new_way = {old_way[63:36], (wk_taken_q ? wk_target_q : old_way[35:4]),
                       ctr_new, 2'b00};
        end else begin
            new_way = {1'b1, tag, wk_target_q, 2'b10, 2'b00};
        end

        way0_new    = sel_way ? way0 : new_way;
        way1_new    = sel_way ? new_way : way1;
        // LRU points at the way that was not touched; set[64] is reserved.
        way0_new[0] = !sel_way;
        way1_new[0] = 1'b0;

        need_write = hit || wk_taken_q;
    end

    // Control FSM with registered write strobe and write data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            write_en    <= 1'b0;
            write_set   <= 128'd0;
            wk_pc_q     <= 30'd0;
            wk_taken_q  <= 1'b0;
            wk_target_q <= 32'd0;
        end else begin
            write_en <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        wk_pc_q     <= fifo_pc[rd_ptr_q];
                        wk_taken_q  <= fifo_taken[rd_ptr_q];
                        wk_target_q <= fifo_target[rd_ptr_q];
                        state_q     <= StLookup;
                    end
                end
                StLookup: begin
                    if (need_write) begin
                        write_set <= {way1_new, way0_new};
                        write_en  <= 1'b1;
                        state_q   <= StWrite;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWrite: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update.sv
// Directed self-checking bench for btb_update with a behavioural BTB file.
module tb_btb_update;

    logic         clk = 1'b0;
    logic         rst;
    logic         upd_valid;
    logic [31:0]  upd_pc;
    logic         upd_taken;
    logic [31:0]  upd_target;
    logic         upd_ready;
    logic [2:0]   update_index;
    logic [127:0] update_set;
    logic [2:0]   write_index;
    logic [127:0] write_set;
    logic         write_en;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // BTB file model, preloadable by the bench.
    logic [127:0] mem [8];
    logic         pre_we;
    logic [2:0]   pre_idx;
    logic [127:0] pre_val;

    // Stream stimulus and hand-computed expected writes.
    logic [31:0]  it_pc     [8];
    logic         it_taken  [8];
    logic [31:0]  it_target [8];
    logic [2:0]   exp_idx   [8];
    logic [127:0] exp_set   [8];
    logic         saw_low;
    int           stray;

    btb_update dut (
        .clk          (clk),
        .rst          (rst),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_ready    (upd_ready),
        .update_index (update_index),
        .update_set   (update_set),
        .write_index  (write_index),
        .write_set    (write_set),
        .write_en     (write_en),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    assign update_set = mem[update_index];

    always @(posedge clk) begin
        if (write_en) begin
            mem[write_index] <= write_set;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_val;
        end
    end

    function automatic logic [63:0] mk(input logic v, input logic [26:0] t,
                                       input logic [31:0] tgt, input logic [1:0] c,
                                       input logic b0);
        return {v, t, tgt, c, 1'b0, b0};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge.
    task automatic preload(input logic [2:0] idx, input logic [127:0] val);
        pre_we  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(posedge clk);
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    // Drives n stream items back-to-back (from index start_acc) and checks every write.
    task automatic run_stream(input int n, input int start_acc);
        int   acc;
        int   nw;
        int   cyc;
        logic r;
        acc = start_acc;
        nw  = 0;
        cyc = 0;
        saw_low = 1'b0;
        while (nw < n && cyc < 100) begin
            if (write_en) begin
                check_eq($sformatf("wr_idx%0d", nw), 128'(write_index), 128'(exp_idx[nw]));
                check_eq($sformatf("wr_set%0d", nw), write_set, exp_set[nw]);
                nw++;
            end
            if (!upd_ready && !saw_low) begin
                saw_low = 1'b1;
                check_eq("full_occupancy", 128'(acc - nw), 128'(4));
            end
            if (acc < n) begin
                upd_valid  = 1'b1;
                upd_pc     = it_pc[acc];
                upd_taken  = it_taken[acc];
                upd_target = it_target[acc];
            end else begin
                upd_valid = 1'b0;
            end
            r = upd_ready;
            @(posedge clk);
            if (upd_valid && r) acc++;
            @(negedge clk);
            cyc++;
        end
        upd_valid = 1'b0;
        check_eq("stream_done", 128'(nw), 128'(n));
    endtask

    task automatic set_item(input int i, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tgt, input logic [2:0] eidx,
                            input logic [127:0] eset);
        it_pc[i]     = pc;
        it_taken[i]  = tk;
        it_target[i] = tgt;
        exp_idx[i]   = eidx;
        exp_set[i]   = eset;
    endtask

    initial begin
        rst        = 1'b0;
        upd_valid  = 1'b0;
        upd_pc     = 32'd0;
        upd_taken  = 1'b0;
        upd_target = 32'd0;
        pre_we     = 1'b0;
        pre_idx    = 3'd0;
        pre_val    = 128'd0;
        stray      = 0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) preload(3'(i), 128'd0);

        // Reset state
        check_eq("rst_ready", 128'(upd_ready), 128'(1));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_wen", 128'(write_en), 128'(0));
        check_eq("rst_wset", write_set, 128'd0);
        check_eq("rst_uidx", 128'(update_index), 128'(0));
        check_eq("rst_widx", 128'(write_index), 128'(0));
        rst = 1'b1;
        @(negedge clk);

        // Allocation into an empty set, with latency check
        upd_valid  = 1'b1;
        upd_pc     = 32'h0000_1008;
        upd_taken  = 1'b1;
        upd_target = 32'h0000_2000;
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        check_eq("alloc_busy", 128'(busy), 128'(1));
        check_eq("alloc_wen0", 128'(write_en), 128'(0));
        @(negedge clk);
        check_eq("alloc_wen1", 128'(write_en), 128'(0));
        @(negedge clk);
        check_eq("alloc_wen2", 128'(write_en), 128'(1));
        check_eq("alloc_widx", 128'(write_index), 128'(2));
        check_eq("alloc_wset", write_set,
                 {64'd0, mk(1'b1, 27'h80, 32'h2000, 2'b10, 1'b1)});
        @(negedge clk);
        check_eq("alloc_wen3", 128'(write_en), 128'(0));
        check_eq("alloc_idle", 128'(busy), 128'(0));

        // Hit way1: saturating increment, then decrement on not-taken
        preload(3'd3, {mk(1'b1, 27'h123, 32'h3330, 2'b11, 1'b0),
                       mk(1'b1, 27'h0AA, 32'h1110, 2'b01, 1'b1)});
        set_item(0, {27'h123, 3'd3, 2'b00}, 1'b1, 32'h5550, 3'd3,
                 {mk(1'b1, 27'h123, 32'h5550, 2'b11, 1'b0),
                  mk(1'b1, 27'h0AA, 32'h1110, 2'b01, 1'b0)});
        set_item(1, {27'h123, 3'd3, 2'b00}, 1'b0, 32'h9999, 3'd3,
                 {mk(1'b1, 27'h123, 32'h5550, 2'b10, 1'b0),
                  mk(1'b1, 27'h0AA, 32'h1110, 2'b01, 1'b0)});
        run_stream(2, 0);

        // Full set miss: LRU selects way1
        preload(3'd5, {mk(1'b1, 27'h022, 32'hB000, 2'b10, 1'b0),
                       mk(1'b1, 27'h011, 32'hA000, 2'b01, 1'b1)});
        set_item(0, {27'h033, 3'd5, 2'b00}, 1'b1, 32'hC000, 3'd5,
                 {mk(1'b1, 27'h033, 32'hC000, 2'b10, 1'b0),
                  mk(1'b1, 27'h011, 32'hA000, 2'b01, 1'b0)});
        run_stream(1, 0);

        // Miss not taken: no write, back to idle after one lookup cycle
        upd_valid  = 1'b1;
        upd_pc     = {27'h044, 3'd5, 2'b00};
        upd_taken  = 1'b0;
        upd_target = 32'hDEAD_0000;
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        check_eq("nt_wen0", 128'(write_en), 128'(0));
        @(negedge clk);
        check_eq("nt_wen1", 128'(write_en), 128'(0));
        check_eq("nt_uidx", 128'(update_index), 128'(5));
        @(negedge clk);
        check_eq("nt_wen2", 128'(write_en), 128'(0));
        check_eq("nt_idle", 128'(busy), 128'(0));

        // Back-to-back stream filling the queue; covers invalid-way and LRU victims
        set_item(0, {27'h100, 3'd0, 2'b00}, 1'b1, 32'h10, 3'd0,
                 {64'd0, mk(1'b1, 27'h100, 32'h10, 2'b10, 1'b1)});
        set_item(1, {27'h101, 3'd1, 2'b00}, 1'b1, 32'h14, 3'd1,
                 {64'd0, mk(1'b1, 27'h101, 32'h14, 2'b10, 1'b1)});
        set_item(2, {27'h102, 3'd0, 2'b00}, 1'b1, 32'h18, 3'd0,
                 {mk(1'b1, 27'h102, 32'h18, 2'b10, 1'b0),
                  mk(1'b1, 27'h100, 32'h10, 2'b10, 1'b0)});
        set_item(3, {27'h103, 3'd0, 2'b00}, 1'b1, 32'h1C, 3'd0,
                 {mk(1'b1, 27'h102, 32'h18, 2'b10, 1'b0),
                  mk(1'b1, 27'h103, 32'h1C, 2'b10, 1'b1)});
        set_item(4, {27'h102, 3'd0, 2'b00}, 1'b1, 32'h20, 3'd0,
                 {mk(1'b1, 27'h102, 32'h20, 2'b11, 1'b0),
                  mk(1'b1, 27'h103, 32'h1C, 2'b10, 1'b0)});
        set_item(5, {27'h105, 3'd4, 2'b00}, 1'b1, 32'h24, 3'd4,
                 {64'd0, mk(1'b1, 27'h105, 32'h24, 2'b10, 1'b1)});
        run_stream(6, 0);
        check_eq("ready_dropped", 128'(saw_low), 128'(1));

        // Same index back-to-back: second lookup sees the first write
        set_item(0, {27'h200, 3'd6, 2'b00}, 1'b1, 32'h40, 3'd6,
                 {64'd0, mk(1'b1, 27'h200, 32'h40, 2'b10, 1'b1)});
        set_item(1, {27'h200, 3'd6, 2'b00}, 1'b1, 32'h40, 3'd6,
                 {64'd0, mk(1'b1, 27'h200, 32'h40, 2'b11, 1'b1)});
        run_stream(2, 0);

        // Reset during a write-bound lookup with three updates queued
        for (int k = 0; k < 5; k++) begin
            upd_valid  = 1'b1;
            upd_pc     = {27'h300 + 27'(k), 3'd7, 2'b00};
            upd_taken  = 1'b1;
            upd_target = 32'h700 + 32'(k);
            @(posedge clk);
            @(negedge clk);
        end
        upd_valid = 1'b0;
        check_eq("pre_rst_busy", 128'(busy), 128'(1));
        rst = 1'b0;
        #1;
        check_eq("abort_wen", 128'(write_en), 128'(0));
        check_eq("abort_busy", 128'(busy), 128'(0));
        check_eq("abort_ready", 128'(upd_ready), 128'(1));
        check_eq("abort_wset", write_set, 128'd0);
        @(negedge clk);
        check_eq("abort_wen_hold", 128'(write_en), 128'(0));

        // Push accepted on the first edge after reset release
        rst        = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = {27'h101, 3'd1, 2'b00};
        upd_taken  = 1'b1;
        upd_target = 32'h44;
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        check_eq("first_push", 128'(busy), 128'(1));
        set_item(0, {27'h101, 3'd1, 2'b00}, 1'b1, 32'h44, 3'd1,
                 {64'd0, mk(1'b1, 27'h101, 32'h44, 2'b11, 1'b1)});
        run_stream(1, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (write_en) stray++;
        end
        check_eq("no_stray_write", 128'(stray), 128'(0));
        check_eq("final_idle", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
